// File: rtl/mp_addsub_pipe.sv
// Multi-cycle add/sub/cond-sub: one S-bit carry-select slice per cycle, LSB first.
// done pulses N+2 cycles after start is taken; start is ignored while busy and taken again in DONE.
module mp_addsub_pipe #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 128,
  parameter int LIMBS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int S  = CHUNK * LIMBS;
  localparam int N  = (WIDTH + S) / S;
  localparam int T  = N * S;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [1:0]     op_q, op_d;
  logic [T-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH:0] result_q, result_d;
  logic           borrow_q, borrow_d;

  logic [31:0]    base;
  logic [S-1:0]   a_sl, b_sl, slice_sum;
  logic           slice_cout;
  logic [T:0]     full;
  logic           a_ge_b;
  logic           sub_in;
  logic [WIDTH:0] b_w;

  assign base   = 32'(cnt_q) * 32'(S);
  assign a_sl   = a_q[base +: S];
  assign b_sl   = b_q[base +: S];
  assign full   = {carry_q, sum_q};
  // Bit WIDTH+1 of a + ~b + 1 is the "no borrow" flag for subtract-type ops.
  assign a_ge_b = full[WIDTH+1];
  assign sub_in = (op == 2'b01) || (op == 2'b10);
  assign b_w    = sub_in ? ~{1'b0, in_b} : {1'b0, in_b};

  always_comb begin : slice_add
    logic [CHUNK:0] s0, s1, sel;
    logic           c;
    s0        = '0;
    s1        = '0;
    sel       = '0;
    c         = carry_q;
    slice_sum = '0;
    for (int l = 0; l < LIMBS; l++) begin
      s0  = {1'b0, a_sl[l*CHUNK +: CHUNK]} + {1'b0, b_sl[l*CHUNK +: CHUNK]};
      s1  = {1'b0, a_sl[l*CHUNK +: CHUNK]} + {1'b0, b_sl[l*CHUNK +: CHUNK]} + (CHUNK+1)'(1);
      sel = c ? s1 : s0;
      slice_sum[l*CHUNK +: CHUNK] = sel[CHUNK-1:0];
      c   = sel[CHUNK];
    end
    slice_cout = c;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    borrow_d = borrow_q;
    case (state_q)
      RUN: begin
        sum_d[base +: S] = slice_sum;
        carry_d          = slice_cout;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        state_d = DONE;
        case (op_q)
          2'b01: begin
            result_d = full[WIDTH:0];
            borrow_d = ~a_ge_b;
          end
          2'b10: begin
            result_d = a_ge_b ? full[WIDTH:0] : {1'b0, a_q[WIDTH-1:0]};
            borrow_d = ~a_ge_b;
          end
          default: begin
            result_d = full[WIDTH:0];
            borrow_d = 1'b0;
          end
        endcase
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
        if (start) begin
          state_d         = RUN;
          op_d            = op;
          a_d             = '0;
          a_d[WIDTH-1:0]  = in_a;
          b_d             = '0;
          b_d[WIDTH:0]    = b_w;
          carry_d         = sub_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
    end
  end

  // Operand and partial-sum storage needs no reset: every slice is rewritten before FIX reads it.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sum_q <= sum_d;
  end

  assign result = result_q;
  assign borrow = borrow_q;
  assign busy   = (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_mp_addsub_pipe.sv
// Bench for mp_addsub_pipe: small (16/4/2) and default-size instances against hand vectors and a model.
module tb_mp_addsub_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sm_start;
  logic [1:0]  sm_op;
  logic [15:0] sm_a, sm_b;
  logic [16:0] sm_result;
  logic        sm_borrow, sm_busy, sm_done;

  logic          bg_start;
  logic [1:0]    bg_op;
  logic [1026:0] bg_a, bg_b;
  logic [1027:0] bg_result;
  logic          bg_borrow, bg_busy, bg_done;

  mp_addsub_pipe #(.WIDTH(16), .CHUNK(4), .LIMBS(2)) dut_sm (
    .clk(clk), .reset(reset), .start(sm_start), .op(sm_op), .in_a(sm_a), .in_b(sm_b),
    .result(sm_result), .borrow(sm_borrow), .busy(sm_busy), .done(sm_done)
  );

  mp_addsub_pipe dut_bg (
    .clk(clk), .reset(reset), .start(bg_start), .op(bg_op), .in_a(bg_a), .in_b(bg_b),
    .result(bg_result), .borrow(bg_borrow), .busy(bg_busy), .done(bg_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] res;
    logic        bor;
  } vec_t;

  task automatic chk(input string nm, input logic [1027:0] act, input logic [1027:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got (low128) %h, want (low128) %h", nm, act[127:0], exp[127:0]);
    end
  endtask

  // Reference: plain wide arithmetic, result reduced mod 2^(w+1). Returns {borrow, result}.
  function automatic logic [1028:0] model(input logic [1:0] op, input logic [1026:0] a,
                                          input logic [1026:0] b, input int w);
    logic [1027:0] mask, r, ea, eb;
    logic bw;
    mask = {1028{1'b1}} >> (1027 - w);
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (op)
      2'b01: begin r = (ea - eb) & mask; bw = (a < b); end
      2'b10: begin
        if (a >= b) begin r = ea - eb; bw = 1'b0; end
        else begin r = ea; bw = 1'b1; end
      end
      default: begin r = ea + eb; bw = 1'b0; end
    endcase
    return {bw, r};
  endfunction

  function automatic logic [1026:0] rand_wide();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[1026:0];
  endfunction

  // Waits up to bound cycles for done; lat = cycles waited (-1 on timeout), nbusy = busy cycles seen.
  task automatic wait_done(input bit big, input int bound, output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (big ? bg_busy : sm_busy) nbusy++;
      if (big ? bg_done : sm_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input bit big, input logic [1:0] op, input logic [1026:0] a,
                       input logic [1026:0] b, output logic [1027:0] res, output logic bor,
                       output int lat, output int nbusy);
    @(negedge clk);
    if (big) begin bg_start = 1'b1; bg_op = op; bg_a = a; bg_b = b; end
    else begin sm_start = 1'b1; sm_op = op; sm_a = a[15:0]; sm_b = b[15:0]; end
    @(posedge clk);
    #1;
    // Scramble inputs after the start edge; the latched operands must be used.
    if (big) begin bg_start = 1'b0; bg_op = 2'($urandom); bg_a = rand_wide(); bg_b = rand_wide(); end
    else begin sm_start = 1'b0; sm_op = 2'($urandom); sm_a = 16'($urandom); sm_b = 16'($urandom); end
    wait_done(big, 20, lat, nbusy);
    res = big ? bg_result : {1011'd0, sm_result};
    bor = big ? bg_borrow : sm_borrow;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[9];
    logic [1027:0] res, exp_r;
    logic [1028:0] m;
    logic bor;
    int lat, nb;
    logic [1:0] rop;
    logic [1026:0] ra, rb;

    tv[0] = '{2'b00, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
    tv[1] = '{2'b01, 16'h1234, 16'h1235, 17'h1FFFF, 1'b1};
    tv[2] = '{2'b01, 16'h1235, 16'h1234, 17'h00001, 1'b0};
    tv[3] = '{2'b10, 16'h0005, 16'h0007, 17'h00005, 1'b1};
    tv[4] = '{2'b10, 16'h0009, 16'h0007, 17'h00002, 1'b0};
    tv[5] = '{2'b11, 16'h8000, 16'h8000, 17'h10000, 1'b0};
    tv[6] = '{2'b10, 16'h1234, 16'h1234, 17'h00000, 1'b0};
    tv[7] = '{2'b01, 16'h0000, 16'hFFFF, 17'h10001, 1'b1};
    tv[8] = '{2'b00, 16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0};

    reset = 1'b1;
    sm_start = 1'b0; sm_op = 2'b00; sm_a = '0; sm_b = '0;
    bg_start = 1'b0; bg_op = 2'b00; bg_a = '0; bg_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_result", {1011'd0, sm_result}, '0);
    chk("reset_borrow", 1028'(sm_borrow), '0);
    chk("reset_busy", 1028'(sm_busy), '0);
    chk("reset_done", 1028'(sm_done), '0);
    chk("reset_big_result", bg_result, '0);

    for (int i = 0; i < 9; i++) begin
      do_op(1'b0, tv[i].op, 1027'(tv[i].a), 1027'(tv[i].b), res, bor, lat, nb);
      chk($sformatf("vec%0d_result", i), res, 1028'(tv[i].res));
      chk($sformatf("vec%0d_borrow", i), 1028'(bor), 1028'(tv[i].bor));
      chk($sformatf("vec%0d_latency", i), 1028'(lat), 1028'(5));
      chk($sformatf("vec%0d_busy_cycles", i), 1028'(nb), 1028'(4));
    end

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = 1027'(16'($urandom));
      rb = (i % 6 == 0) ? ra : 1027'(16'($urandom));
      m = model(rop, ra, rb, 16);
      do_op(1'b0, rop, ra, rb, res, bor, lat, nb);
      chk($sformatf("rnd%0d_result", i), res, m[1027:0]);
      chk($sformatf("rnd%0d_borrow", i), 1028'(bor), 1028'(m[1028]));
    end

    // Default size: carry rippling through every limb and slice boundary.
    do_op(1'b1, 2'b00, {1027{1'b1}}, 1027'(1), res, bor, lat, nb);
    exp_r = '0;
    exp_r[1027] = 1'b1;
    chk("big_ones_plus_one", res, exp_r);
    chk("big_ones_borrow", 1028'(bor), '0);
    chk("big_latency", 1028'(lat), 1028'(5));

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = rand_wide();
      rb = (i == 3) ? ra : rand_wide();
      m = model(rop, ra, rb, 1027);
      do_op(1'b1, rop, ra, rb, res, bor, lat, nb);
      chk($sformatf("big_rnd%0d_result", i), res, m[1027:0]);
      chk($sformatf("big_rnd%0d_borrow", i), 1028'(bor), 1028'(m[1028]));
    end

    // Start held high: second op taken in the DONE cycle.
    @(negedge clk);
    sm_start = 1'b1; sm_op = 2'b00; sm_a = 16'h0001; sm_b = 16'h0002;
    @(posedge clk);
    #1;
    sm_op = 2'b01; sm_a = 16'h0100; sm_b = 16'h0023;
    wait_done(1'b0, 20, lat, nb);
    chk("held_first_latency", 1028'(lat), 1028'(5));
    chk("held_first_result", 1028'(sm_result), 1028'(17'h00003));
    wait_done(1'b0, 20, lat, nb);
    sm_start = 1'b0;
    chk("held_second_latency", 1028'(lat), 1028'(5));
    chk("held_second_busy", 1028'(nb), 1028'(4));
    chk("held_second_result", 1028'(sm_result), 1028'(17'h000DD));
    chk("held_second_borrow", 1028'(sm_borrow), '0);

    // Start pulse during busy is ignored.
    @(negedge clk);
    sm_start = 1'b1; sm_op = 2'b01; sm_a = 16'h0050; sm_b = 16'h0010;
    @(posedge clk);
    #1;
    sm_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sm_start = 1'b1; sm_op = 2'b00; sm_a = 16'hFFFF; sm_b = 16'hFFFF;
    @(negedge clk);
    sm_start = 1'b0;
    wait_done(1'b0, 20, lat, nb);
    chk("pulse_latency", 1028'(lat + 3), 1028'(5));
    chk("pulse_result", 1028'(sm_result), 1028'(17'h00040));
    wait_done(1'b0, 12, lat, nb);
    chk("pulse_no_second_done", 1028'(lat == -1), 1028'(1));

    // Reset two cycles after start aborts the operation.
    @(negedge clk);
    sm_start = 1'b1; sm_op = 2'b00; sm_a = 16'hFFFF; sm_b = 16'h0001;
    @(posedge clk);
    #1;
    sm_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 1028'(sm_busy), '0);
    chk("abort_result", 1028'(sm_result), '0);
    wait_done(1'b0, 10, lat, nb);
    chk("abort_no_done", 1028'(lat == -1), 1028'(1));

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b1; sm_start = 1'b1; sm_op = 2'b00; sm_a = 16'h0005; sm_b = 16'h0006;
    @(negedge clk);
    reset = 1'b0; sm_start = 1'b0;
    chk("prio_busy", 1028'(sm_busy), '0);
    wait_done(1'b0, 10, lat, nb);
    chk("prio_no_done", 1028'(lat == -1), 1028'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
